// File: rtl/cic_decimator_param_if.sv
// rtl/cic_decimator_param_if.sv - sample-in / decimated-out bundle for cic_decimator_param
interface cic_decimator_param_if #(
  parameter int IN_WIDTH      = 1,
  parameter int RATE_MAX_LOG2 = 4,
  parameter int OUT_WIDTH     = 8
);
  localparam int RW = $clog2(RATE_MAX_LOG2 + 1);

  logic                        in_valid;
  logic [IN_WIDTH-1:0]         in_data;
  logic [RW-1:0]               rate_log2;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        clip;

  modport master (
    output in_valid, in_data, rate_log2,
    input  out_valid, out_data, clip
  );

  modport slave (
    input  in_valid, in_data, rate_log2,
    output out_valid, out_data, clip
  );
endinterface

// File: rtl/cic_decimator_param.sv
// rtl/cic_decimator_param.sv - N-stage CIC decimator, runtime power-of-two rate, normalised saturated output
module cic_decimator_param #(
  parameter int N_STAGES      = 3,
  parameter int IN_WIDTH      = 1,
  parameter int RATE_MAX_LOG2 = 4,
  parameter int OUT_WIDTH     = 8
) (
  input logic                 clk,
  input logic                 rst,
  cic_decimator_param_if.slave bus
);
  localparam int INE = (IN_WIDTH == 1) ? 1 : IN_WIDTH;
  localparam int W   = ((IN_WIDTH > 2) ? IN_WIDTH : 2) + N_STAGES * RATE_MAX_LOG2;
  localparam int RW  = $clog2(RATE_MAX_LOG2 + 1);
  localparam int CW  = (RATE_MAX_LOG2 > 0) ? RATE_MAX_LOG2 : 1;
  localparam int WW  = $clog2(N_STAGES + 1);
  localparam int WE  = W + OUT_WIDTH;
  localparam logic signed [WE-1:0] SAT_MAX = {{(WE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WE-1:0] SAT_MIN = {{(WE-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [W-1:0]         integ    [N_STAGES];
  logic signed [W-1:0]         integ_nx [N_STAGES];
  logic signed [W-1:0]         comb_dly [N_STAGES];
  logic signed [W-1:0]         comb_in  [N_STAGES];
  logic signed [W-1:0]         integ_run;
  logic signed [W-1:0]         comb_run;
  logic signed [W-1:0]         x_ext;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               cnt_last;
  logic [RW-1:0]               rate;
  logic [RW-1:0]               rate_req;
  logic [WW-1:0]               warm;
  logic                        dec;
  logic                        wrap;
  int                          shift;
  logic signed [WE-1:0]        y_ext;
  logic signed [WE-1:0]        y_scaled;
  logic signed [OUT_WIDTH-1:0] y_sat;
  logic                        y_clip;
  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic                        clip_q;

  if (IN_WIDTH == 1) begin : g_pdm
    assign x_ext = bus.in_data[0] ? W'(1) : {W{1'b1}};
  end else begin : g_pcm
    assign x_ext = {{(W-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
  end

  assign rate_req = (bus.rate_log2 > RW'(RATE_MAX_LOG2)) ? RW'(RATE_MAX_LOG2) : bus.rate_log2;
  assign cnt_last = CW'((32'd1 << rate) - 32'd1);
  assign wrap     = (cnt == cnt_last);

  // Each integrator adds the freshly updated value of the stage before it.
  always_comb begin
    integ_run = x_ext;
    for (int i = 0; i < N_STAGES; i++) begin
      integ_run   = integ[i] + integ_run;
      integ_nx[i] = integ_run;
    end
  end

  always_comb begin
    comb_run = integ[N_STAGES-1];
    for (int i = 0; i < N_STAGES; i++) begin
      comb_in[i] = comb_run;
      comb_run   = comb_run - comb_dly[i];
    end
  end

  // Gain R^N is normalised back to the output range; negative shift means the output is wider than the gain.
  always_comb begin
    y_ext = {{OUT_WIDTH{comb_run[W-1]}}, comb_run};
    shift = N_STAGES * int'(rate) - (OUT_WIDTH - INE);
    if (shift >= 0) y_scaled = y_ext >>> shift;
    else            y_scaled = y_ext <<< (-shift);
    y_sat  = y_scaled[OUT_WIDTH-1:0];
    y_clip = 1'b0;
    if (y_scaled > SAT_MAX) begin
      y_sat  = SAT_MAX[OUT_WIDTH-1:0];
      y_clip = 1'b1;
    end else if (y_scaled < SAT_MIN) begin
      y_sat  = SAT_MIN[OUT_WIDTH-1:0];
      y_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_STAGES; i++) begin
        integ[i]    <= '0;
        comb_dly[i] <= '0;
      end
      cnt         <= '0;
      rate        <= rate_req;
      warm        <= WW'(N_STAGES);
      dec         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      clip_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      dec         <= 1'b0;
      if (dec) begin
        for (int i = 0; i < N_STAGES; i++) comb_dly[i] <= comb_in[i];
        if (warm != '0) begin
          warm <= warm - WW'(1);
        end else begin
          out_data_q  <= y_sat;
          clip_q      <= y_clip;
          out_valid_q <= 1'b1;
        end
      end
      if (bus.in_valid) begin
        for (int i = 0; i < N_STAGES; i++) integ[i] <= integ_nx[i];
        if (wrap) begin
          cnt <= '0;
          dec <= 1'b1;
          // A rate switch overrides any decrement above so the new rate always gets a full warm-up.
          if (rate_req != rate) begin
            rate <= rate_req;
            warm <= WW'(N_STAGES);
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.clip      = clip_q;
endmodule
